// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Source-side video timing generator. Divides clk_sys into a pixel enable,
//   walks the raster with horizontal/vertical counters, requests the next
//   pixel from the framebuffer/renderer and emits registered sync, blank and
//   blanked RGB, all aligned to the same ce_pix boundary.
//
// Ports
//   clk_sys      in   system clock, all logic on posedge
//   reset        in   synchronous, active-high reset (priority over ce_pix)
//   ce_pix       out  pixel enable, one clk_sys pulse every CE_DIV cycles
//   pix_x/pix_y  out  coordinate of the pixel emitted at the next ce_pix
//   pix_rd       out  (pix_x,pix_y) lies inside the active area
//   r/g/b_in     in   colour of (pix_x,pix_y), DW bits per channel
//   hs/vs_out    out  horizontal/vertical sync, active high
//   hb/vb_out    out  horizontal/vertical blank
//   r/g/b_out    out  colour of the current pixel, 0 while blanked
//   frame_start  out  high for the pixel period of (0,0)
module video_timing_gen #(
  parameter int CE_DIV     = 4,
  parameter int H_ACTIVE   = 256,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 192,
  parameter int V_FP       = 56,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 60,
  parameter int HALF_DEPTH = 0,
  localparam int DW        = (HALF_DEPTH != 0) ? 4 : 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  output logic          ce_pix,
  output logic [11:0]   pix_x,
  output logic [11:0]   pix_y,
  output logic          pix_rd,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          frame_start
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOT - 1);
  localparam logic [7:0]  D_LAST = 8'(CE_DIV - 1);

  logic [7:0]  dcnt;
  logic [11:0] hcnt;
  logic [11:0] vcnt;

  // The fetch coordinate is simply the successor of the current position,
  // so it needs no state of its own and stays stable between pixel enables.
  always_comb begin
    pix_x = (hcnt == H_LAST) ? '0 : hcnt + 12'd1;
    pix_y = vcnt;
    if (hcnt == H_LAST) begin
      pix_y = (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
    end
    pix_rd = (int'(pix_x) < H_ACTIVE) && (int'(pix_y) < V_ACTIVE);
  end

  // On each pixel enable the fetched position becomes the current one; its
  // flags and colour are registered together so every output stays aligned.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dcnt        <= '0;
      ce_pix      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      hb_out      <= 1'b0;
      vb_out      <= 1'b0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      frame_start <= 1'b0;
    end else begin
      dcnt   <= (dcnt == D_LAST) ? '0 : dcnt + 8'd1;
      ce_pix <= (dcnt == D_LAST);
      if (ce_pix) begin
        hcnt        <= pix_x;
        vcnt        <= pix_y;
        hb_out      <= int'(pix_x) >= H_ACTIVE;
        hs_out      <= (int'(pix_x) >= HS_BEG) && (int'(pix_x) < HS_END);
        vb_out      <= int'(pix_y) >= V_ACTIVE;
        vs_out      <= (int'(pix_y) >= VS_BEG) && (int'(pix_y) < VS_END);
        frame_start <= (pix_x == '0) && (pix_y == '0);
        r_out       <= pix_rd ? r_in : '0;
        g_out       <= pix_rd ? g_in : '0;
        b_out       <= pix_rd ? b_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int CE   = 4;
  localparam int HT   = 16;
  localparam int VT   = 8;
  localparam int NPIX = HT * VT;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ce_pix;
  logic [11:0] pix_x, pix_y;
  logic        pix_rd;
  logic [7:0]  r_in, g_in, b_in;
  logic        hs_out, vs_out, hb_out, vb_out;
  logic [7:0]  r_out, g_out, b_out;
  logic        frame_start;

  video_timing_gen #(
    .CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HALF_DEPTH(0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rd(pix_rd),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_start(frame_start)
  );

  always #5 clk_sys = ~clk_sys;

  // Framebuffer contents, indexed by y*HT+x
  logic [7:0] rm [NPIX];
  logic [7:0] gm [NPIX];
  logic [7:0] bm [NPIX];
  int src_idx;

  always_comb begin
    src_idx = int'(pix_y) * HT + int'(pix_x);
    r_in = '0;
    g_in = '0;
    b_in = '0;
    if (src_idx < NPIX) begin
      r_in = rm[src_idx];
      g_in = gm[src_idx];
      b_in = bm[src_idx];
    end
  end

  int errors = 0;
  int checks = 0;
  // Reference model: clocks since reset release and pixels completed since reset
  int cyc  = 0;
  int done = 0;

  task automatic fill_mem();
    for (int i = 0; i < NPIX; i++) begin
      rm[i] = 8'($urandom);
      gm[i] = 8'($urandom);
      bm[i] = 8'($urandom);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (done=%0d cyc=%0d)", nm, act, exp, done, cyc);
    end
  endtask

  function automatic int exp_ce();
    return (cyc > 0 && (cyc % CE) == 0) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int old_ce;
    old_ce = exp_ce();
    if (reset) begin
      cyc  = 0;
      done = 0;
    end else begin
      if (old_ce != 0) done++;
      cyc++;
    end
  endtask

  task automatic check_model();
    int idx, x, y, nidx, act;
    int e_hb, e_hs, e_vb, e_vs, e_fs, e_r, e_g, e_b;
    nidx = (done + 1) % NPIX;
    e_hb = 0; e_hs = 0; e_vb = 0; e_vs = 0; e_fs = 0; e_r = 0; e_g = 0; e_b = 0;
    if (done > 0) begin
      idx  = done % NPIX;
      x    = idx % HT;
      y    = idx / HT;
      e_hb = (x >= 8) ? 1 : 0;
      e_hs = (x >= 10 && x < 13) ? 1 : 0;
      e_vb = (y >= 4) ? 1 : 0;
      e_vs = (y >= 5 && y < 7) ? 1 : 0;
      e_fs = (idx == 0) ? 1 : 0;
      act  = (x < 8 && y < 4) ? 1 : 0;
      if (act != 0) begin
        e_r = int'(rm[idx]);
        e_g = int'(gm[idx]);
        e_b = int'(bm[idx]);
      end
    end
    chk("ce_pix", int'(ce_pix), exp_ce());
    chk("hb", int'(hb_out), e_hb);
    chk("hs", int'(hs_out), e_hs);
    chk("vb", int'(vb_out), e_vb);
    chk("vs", int'(vs_out), e_vs);
    chk("frame_start", int'(frame_start), e_fs);
    chk("pix_x", int'(pix_x), nidx % HT);
    chk("pix_y", int'(pix_y), nidx / HT);
    chk("pix_rd", int'(pix_rd), ((nidx % HT) < 8 && (nidx / HT) < 4) ? 1 : 0);
    chk("r_out", int'(r_out), e_r);
    chk("g_out", int'(g_out), e_g);
    chk("b_out", int'(b_out), e_b);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    check_model();
  endtask

  task automatic run_to(input int tgt);
    int n;
    n = 0;
    while (done < tgt && n < 4000) begin
      tick();
      n++;
    end
    if (done != tgt) begin
      checks++;
      errors++;
      $display("FAIL run_to: reached %0d required %0d", done, tgt);
    end
  endtask

  typedef struct {
    int tgt;
    int hb, hs, vb, vs, fs;
    int px, py, rd;
  } vec_t;

  vec_t tv [13];

  initial begin
    tv[0]  = '{0,   0, 0, 0, 0, 0,  1, 0, 1};
    tv[1]  = '{7,   0, 0, 0, 0, 0,  8, 0, 0};
    tv[2]  = '{9,   1, 0, 0, 0, 0, 10, 0, 0};
    tv[3]  = '{10,  1, 1, 0, 0, 0, 11, 0, 0};
    tv[4]  = '{12,  1, 1, 0, 0, 0, 13, 0, 0};
    tv[5]  = '{13,  1, 0, 0, 0, 0, 14, 0, 0};
    tv[6]  = '{15,  1, 0, 0, 0, 0,  0, 1, 1};
    tv[7]  = '{16,  0, 0, 0, 0, 0,  1, 1, 1};
    tv[8]  = '{64,  0, 0, 1, 0, 0,  1, 4, 0};
    tv[9]  = '{80,  0, 0, 1, 1, 0,  1, 5, 0};
    tv[10] = '{112, 0, 0, 1, 0, 0,  1, 7, 0};
    tv[11] = '{127, 1, 0, 1, 0, 0,  0, 0, 1};
    tv[12] = '{128, 0, 0, 0, 0, 1,  1, 0, 1};

    fill_mem();

    // Pixel-enable cadence after reset release: high on clocks 4 and 8 only
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("ce_cadence", int'(ce_pix), (i % 4 == 0) ? 1 : 0);
    end

    // Table of landmark pixels through one frame
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      run_to(tv[i].tgt);
      chk("vec_hb", int'(hb_out), tv[i].hb);
      chk("vec_hs", int'(hs_out), tv[i].hs);
      chk("vec_vb", int'(vb_out), tv[i].vb);
      chk("vec_vs", int'(vs_out), tv[i].vs);
      chk("vec_fs", int'(frame_start), tv[i].fs);
      chk("vec_pix_x", int'(pix_x), tv[i].px);
      chk("vec_pix_y", int'(pix_y), tv[i].py);
      chk("vec_pix_rd", int'(pix_rd), tv[i].rd);
    end

    // One-clock reset mid-line while hsync is active at hcnt=11
    run_to(128 + 11);
    chk("midreset_hs_before", int'(hs_out), 1);
    reset = 1'b1;
    tick();
    chk("midreset_hs", int'(hs_out), 0);
    chk("midreset_ce", int'(ce_pix), 0);
    chk("midreset_r", int'(r_out), 0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("midreset_cadence", int'(ce_pix), (i % 4 == 0) ? 1 : 0);
    end

    // Random reset pulses over a long run, new framebuffer contents each time
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        fill_mem();
        repeat ($urandom_range(1, 3)) tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
